booth_mul_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one radix-4 Booth 8x8 multiplier among NREQ requesters.
//  - Accepts one request at a time and registers its operands.
//  - Drives the multiplier's go/over protocol and returns the 16-bit signed product to the winning requester.
//  - Sits between requester blocks and the multiplier; owns the multiplier's reset.

---
 rtl/booth_mul_arbiter_if.sv | 31 +++
 rtl/booth_mul_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_arbiter_if.sv
// Requester-side and multiplier-side signal bundle for booth_mul_arbiter.
// slave = the arbiter's view, master = the requesters plus the multiplier.
interface booth_mul_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_mplier;
  logic [8*NREQ-1:0] req_mpcand;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [15:0]       resp_pdt;
  logic              resp_err;
  logic              mul_go;
  logic [7:0]        mul_mplier;
  logic [7:0]        mul_mpcand;
  logic              mul_reset;
  logic [15:0]       mul_pdt;
  logic              mul_over;

  modport slave (
    input  req_valid, req_mplier, req_mpcand, mul_pdt, mul_over,
    output req_ready, resp_valid, resp_pdt, resp_err,
           mul_go, mul_mplier, mul_mpcand, mul_reset
  );

  modport master (
    output req_valid, req_mplier, req_mpcand, mul_pdt, mul_over,
    input  req_ready, resp_valid, resp_pdt, resp_err,
           mul_go, mul_mplier, mul_mpcand, mul_reset
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one radix-4 Booth 8x8 multiplier (go/over protocol) among NREQ requesters.
// Defining BOOTH_ARB_TIMEOUT_EN adds a WAIT watchdog that aborts the job and resets the multiplier.
module booth_mul_arbiter #(
  parameter int NREQ      = 2,
  parameter int TIMEOUT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  booth_mul_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_W < 1) begin : g_bad_params
    $error("booth_mul_arbiter: NREQ must be 2..8 and TIMEOUT_W at least 1");
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_RSTM  = 3'd0,
    S_IDLE  = 3'd1,
    S_EXIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5,
    S_ABORT = 3'd6
  } state_e;
`else
  typedef enum logic [2:0] {
    S_RSTM  = 3'd0,
    S_IDLE  = 3'd1,
    S_EXIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_e;
`endif

  state_e          state_q, state_d;
  logic            parked_q, parked_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [7:0]      mplier_q, mplier_d;
  logic [7:0]      mpcand_q, mpcand_d;
  logic [15:0]     pdt_q, pdt_d;
  logic            go_q, go_d;
  logic            mrst_q, mrst_d;
  logic            err_q, err_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic            found_s;
  logic [IW-1:0]   grant_s;
  logic [IW-1:0]   cand_s;
`ifdef BOOTH_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
`endif

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    if (int'(p) >= NREQ - 1) begin
      next_ptr = {IW{1'b0}};
    end else begin
      next_ptr = p + IW'(1);
    end
  endfunction

  // Round-robin pick: scan downward so the closest valid requester at or after rr_ptr wins.
  always_comb begin
    int idx;
    found_s = 1'b0;
    grant_s = {IW{1'b0}};
    cand_s  = {IW{1'b0}};
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      cand_s = IW'(idx);
      if (bus.req_valid[cand_s]) begin
        found_s = 1'b1;
        grant_s = cand_s;
      end else begin
        found_s = found_s;
        grant_s = grant_s;
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE && found_s) ? onehot(grant_s) : {NREQ{1'b0}};

  // Sequencer next state; every output flop is computed here so outputs track the state they belong to.
  always_comb begin
    state_d  = state_q;
    parked_d = parked_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    mplier_d = mplier_q;
    mpcand_d = mpcand_q;
    pdt_d    = pdt_q;
    go_d     = 1'b0;
    mrst_d   = 1'b0;
    err_d    = 1'b0;
    rvalid_d = {NREQ{1'b0}};
`ifdef BOOTH_ARB_TIMEOUT_EN
    wd_d     = wd_q;
`endif
    case (state_q)
      S_RSTM: begin
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (found_s) begin
          mplier_d = bus.req_mplier[{grant_s, 3'b000} +: 8];
          mpcand_d = bus.req_mpcand[{grant_s, 3'b000} +: 8];
          owner_d  = grant_s;
          go_d     = 1'b1;
          state_d  = parked_q ? S_EXIT : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      // A parked multiplier sits in its done state and needs one extra go to get back to idle.
      S_EXIT: begin
        go_d    = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef BOOTH_ARB_TIMEOUT_EN
        wd_d    = {TIMEOUT_W{1'b0}};
`endif
      end
      S_WAIT: begin
        if (bus.mul_over) begin
          pdt_d    = bus.mul_pdt;
          parked_d = 1'b1;
          rvalid_d = onehot(owner_q);
          state_d  = S_DONE;
        end else begin
`ifdef BOOTH_ARB_TIMEOUT_EN
          wd_d = wd_q + TIMEOUT_W'(1);
          if (wd_d == {TIMEOUT_W{1'b1}}) begin
            mrst_d   = 1'b1;
            parked_d = 1'b0;
            pdt_d    = 16'h0000;
            err_d    = 1'b1;
            rvalid_d = onehot(owner_q);
            state_d  = S_ABORT;
          end else begin
            state_d = S_WAIT;
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_DONE: begin
        rr_ptr_d = next_ptr(owner_q);
        state_d  = S_IDLE;
      end
`ifdef BOOTH_ARB_TIMEOUT_EN
      S_ABORT: begin
        rr_ptr_d = next_ptr(owner_q);
        state_d  = S_IDLE;
      end
`endif
      default: begin
        mrst_d  = 1'b1;
        state_d = S_RSTM;
      end
    endcase
  end

  // State and output registers; reset parks the FSM in RSTM with the multiplier held in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RSTM;
      parked_q <= 1'b0;
      rr_ptr_q <= {IW{1'b0}};
      owner_q  <= {IW{1'b0}};
      mplier_q <= 8'h00;
      mpcand_q <= 8'h00;
      pdt_q    <= 16'h0000;
      go_q     <= 1'b0;
      mrst_q   <= 1'b1;
      err_q    <= 1'b0;
      rvalid_q <= {NREQ{1'b0}};
`ifdef BOOTH_ARB_TIMEOUT_EN
      wd_q     <= {TIMEOUT_W{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      parked_q <= parked_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      mplier_q <= mplier_d;
      mpcand_q <= mpcand_d;
      pdt_q    <= pdt_d;
      go_q     <= go_d;
      mrst_q   <= mrst_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
`ifdef BOOTH_ARB_TIMEOUT_EN
      wd_q     <= wd_d;
`endif
    end
  end

  assign bus.resp_valid = rvalid_q;
  assign bus.resp_pdt   = pdt_q;
  assign bus.resp_err   = err_q;
  assign bus.mul_go     = go_q;
  assign bus.mul_mplier = mplier_q;
  assign bus.mul_mpcand = mpcand_q;
  assign bus.mul_reset  = mrst_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter: behavioural go/over multiplier plus a round-robin/product reference model.
// The watchdog scenario runs only when BOOTH_ARB_TIMEOUT_EN is defined.
module tb_booth_mul_arbiter;
  localparam int NREQ = 2;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   exp_ptr;
  bit   exp_parked;
  bit   stall;
  int   mul_lat;
  int   m_a, m_b, m_cnt;
  bit   m_busy;

  booth_mul_arbiter_if #(.NREQ(NREQ)) bus ();

  booth_mul_arbiter #(.NREQ(NREQ), .TIMEOUT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: go in idle loads, over rises mul_lat edges later and holds until the next go.
  always @(posedge clk) begin
    if (bus.mul_reset) begin
      m_busy       <= 1'b0;
      m_cnt        <= 0;
      bus.mul_over <= 1'b0;
    end else if (bus.mul_over) begin
      if (bus.mul_go) bus.mul_over <= 1'b0;
    end else if (m_busy) begin
      if (!stall) begin
        if (m_cnt <= 1) begin
          m_busy       <= 1'b0;
          bus.mul_over <= 1'b1;
          bus.mul_pdt  <= 16'(m_a * m_b);
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end else if (bus.mul_go) begin
      m_busy <= 1'b1;
      m_cnt  <= mul_lat;
      m_a    <= int'($signed(bus.mul_mplier));
      m_b    <= int'($signed(bus.mul_mpcand));
    end
  end

  function automatic int pick(input logic [1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ptr + k) % NREQ;
      if (v[j[0]]) return j;
    end
    return -1;
  endfunction

  function automatic logic [15:0] prod(input logic [15:0] mpl, input logic [15:0] mpc, input int g);
    logic signed [7:0] a;
    logic signed [7:0] b;
    a = (g == 1) ? mpl[15:8] : mpl[7:0];
    b = (g == 1) ? mpc[15:8] : mpc[7:0];
    return 16'(int'(a) * int'(b));
  endfunction

  // Presents one request and records what the DUT does with it; all judging happens in the callers.
  task automatic run_job(input logic [1:0] vld, input logic [15:0] mpl, input logic [15:0] mpc, input bit hold,
                         output logic [1:0] gnt, output int gos, output logic [7:0] opa, output logic [7:0] opb,
                         output logic [1:0] rv, output logic [15:0] pdt, output logic err, output logic mrst,
                         output int lat, output bit to, output logic [1:0] rdy_busy);
    @(posedge clk);
    #1;
    mul_lat        = int'($urandom_range(5, 1));
    bus.req_valid  = vld;
    bus.req_mplier = mpl;
    bus.req_mpcand = mpc;
    gnt = 2'b00; gos = 0; opa = 8'h00; opb = 8'h00; rv = 2'b00; pdt = 16'h0000;
    err = 1'b0; mrst = 1'b0; lat = 0; to = 1'b1; rdy_busy = 2'b00;
    for (int i = 0; i < 20; i++) begin
      if (gnt == 2'b00) begin
        @(negedge clk);
        if ((bus.req_ready & bus.req_valid) != 2'b00) gnt = bus.req_ready;
      end
    end
    if (gnt != 2'b00) begin
      @(posedge clk);
      #1;
      if (!hold) bus.req_valid = 2'b00;
      for (int i = 1; i <= 40; i++) begin
        if (to) begin
          @(negedge clk);
          if (bus.mul_go) begin
            if (gos == 0) begin
              opa = bus.mul_mplier;
              opb = bus.mul_mpcand;
            end
            gos++;
          end
          if (bus.resp_valid != 2'b00) begin
            rv = bus.resp_valid; pdt = bus.resp_pdt; err = bus.resp_err; mrst = bus.mul_reset;
            lat = i; to = 1'b0;
          end else begin
            rdy_busy = rdy_busy | bus.req_ready;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req_valid  = 2'b11;
    bus.req_mplier = 16'h1234;
    bus.req_mpcand = 16'h5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.mul_reset, bus.req_ready, bus.resp_valid, bus.resp_pdt, bus.resp_err, bus.mul_go, bus.mul_mplier, bus.mul_mpcand}
          !== {1'b1, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00}) begin
        n_fail++;
        $display("FAIL reset_outputs: cycle %0d got rst=%b rdy=%b rv=%b pdt=%h err=%b go=%b a=%h b=%h, required rst=1 others 0",
                 i, bus.mul_reset, bus.req_ready, bus.resp_valid, bus.resp_pdt, bus.resp_err, bus.mul_go,
                 bus.mul_mplier, bus.mul_mpcand);
      end
    end
    bus.req_valid = 2'b00;
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus.mul_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_pulse: got mul_reset=%b required 1", bus.mul_reset);
    end
    @(negedge clk);
    n_tests++;
    if (bus.mul_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulse_end: got mul_reset=%b required 0", bus.mul_reset);
    end
    exp_ptr = 0;
    exp_parked = 1'b0;
  endtask

  task automatic test_basic();
    logic [1:0] gnt, rv, rdyb; logic [7:0] opa, opb; logic [15:0] pdt; logic err, mrst; int gos, lat, elat; bit to;
    run_job(2'b01, 16'h0007, 16'h00FD, 1'b0, gnt, gos, opa, opb, rv, pdt, err, mrst, lat, to, rdyb);
    elat = mul_lat + 3;
    n_tests++;
    if ({to, gnt, 4'(gos), rv, pdt, err} !== {1'b0, 2'b01, 4'd1, 2'b01, 16'hFFEB, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: got to=%b gnt=%b go=%0d rv=%b pdt=%h err=%b required to=0 gnt=01 go=1 rv=01 pdt=ffeb err=0",
               to, gnt, gos, rv, pdt, err);
    end
    n_tests++;
    if ({opa, opb, rdyb} !== {8'h07, 8'hFD, 2'b00} || lat != elat || lat > 16) begin
      n_fail++;
      $display("FAIL basic_ops_latency: got a=%h b=%h busy_ready=%b lat=%0d required a=07 b=fd busy_ready=00 lat=%0d",
               opa, opb, rdyb, lat, elat);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.resp_valid, bus.resp_pdt} !== {2'b00, 16'hFFEB}) begin
      n_fail++;
      $display("FAIL basic_pulse_hold: got rv=%b pdt=%h required rv=00 pdt=ffeb", bus.resp_valid, bus.resp_pdt);
    end
    exp_ptr = 1;
    exp_parked = 1'b1;
  endtask

  task automatic test_parked();
    logic [1:0] gnt, rv, rdyb; logic [7:0] opa, opb; logic [15:0] pdt; logic err, mrst; int gos, lat, elat; bit to;
    run_job(2'b10, 16'h0C00, 16'h0500, 1'b0, gnt, gos, opa, opb, rv, pdt, err, mrst, lat, to, rdyb);
    elat = mul_lat + 4;
    n_tests++;
    if ({to, gnt, 4'(gos), rv, pdt, err} !== {1'b0, 2'b10, 4'd2, 2'b10, 16'h003C, 1'b0}) begin
      n_fail++;
      $display("FAIL parked_result: got to=%b gnt=%b go=%0d rv=%b pdt=%h err=%b required to=0 gnt=10 go=2 rv=10 pdt=003c err=0",
               to, gnt, gos, rv, pdt, err);
    end
    n_tests++;
    if ({opa, opb} !== {8'h0C, 8'h05} || lat != elat) begin
      n_fail++;
      $display("FAIL parked_ops_latency: got a=%h b=%h lat=%0d required a=0c b=05 lat=%0d", opa, opb, lat, elat);
    end
    exp_ptr = 0;
    exp_parked = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [1:0] gnt, rv, rdyb, egnt; logic [7:0] opa, opb; logic [15:0] pdt, epdt, mpl, mpc;
    logic err, mrst; int gos, lat, g; bit to;
    mpl = {8'($urandom), 8'h80};
    mpc = {8'($urandom), 8'h80};
    for (int j = 0; j < 4; j++) begin
      g    = pick(2'b11, exp_ptr);
      egnt = 2'(1 << g);
      epdt = (g == 0) ? 16'h4000 : prod(mpl, mpc, 1);
      run_job(2'b11, mpl, mpc, 1'b1, gnt, gos, opa, opb, rv, pdt, err, mrst, lat, to, rdyb);
      n_tests++;
      if ({to, gnt, rv, pdt, err, rdyb, 4'(gos)} !== {1'b0, egnt, egnt, epdt, 1'b0, 2'b00, 4'd2}) begin
        n_fail++;
        $display("FAIL b2b_job%0d: got to=%b gnt=%b rv=%b pdt=%h err=%b busy_ready=%b go=%0d required gnt=%b rv=%b pdt=%h go=2",
                 j, to, gnt, rv, pdt, err, rdyb, gos, egnt, egnt, epdt);
      end
      exp_ptr = (g + 1) % NREQ;
    end
    bus.req_valid = 2'b00;
    exp_parked = 1'b1;
  endtask

  task automatic test_random();
    logic [1:0] gnt, rv, rdyb, vld, egnt; logic [7:0] opa, opb; logic [15:0] pdt, epdt, mpl, mpc;
    logic err, mrst; int gos, lat, elat, egos, g; bit to;
    for (int j = 0; j < 12; j++) begin
      vld  = 2'($urandom_range(3, 1));
      mpl  = 16'($urandom);
      mpc  = 16'($urandom);
      g    = pick(vld, exp_ptr);
      egnt = 2'(1 << g);
      epdt = prod(mpl, mpc, g);
      egos = exp_parked ? 2 : 1;
      run_job(vld, mpl, mpc, 1'b0, gnt, gos, opa, opb, rv, pdt, err, mrst, lat, to, rdyb);
      elat = mul_lat + 2 + egos;
      n_tests++;
      if ({to, gnt, rv, pdt, err, 4'(gos)} !== {1'b0, egnt, egnt, epdt, 1'b0, 4'(egos)} || lat != elat) begin
        n_fail++;
        $display("FAIL rand_job%0d: got to=%b gnt=%b rv=%b pdt=%h err=%b go=%0d lat=%0d required gnt=%b rv=%b pdt=%h go=%0d lat=%0d",
                 j, to, gnt, rv, pdt, err, gos, lat, egnt, egnt, epdt, egos, elat);
      end
      exp_ptr = (g + 1) % NREQ;
      exp_parked = 1'b1;
    end
  endtask

  task automatic test_reset_midop();
    logic [1:0] gnt, rv, rdyb, seen; logic [7:0] opa, opb; logic [15:0] pdt; logic err, mrst, rst_hi;
    int gos, lat; bit to;
    stall = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid  = 2'b01;
    bus.req_mplier = 16'h0021;
    bus.req_mpcand = 16'h0013;
    gnt = 2'b00;
    for (int i = 0; i < 20; i++) begin
      if (gnt == 2'b00) begin
        @(negedge clk);
        if ((bus.req_ready & bus.req_valid) != 2'b00) gnt = bus.req_ready;
      end
    end
    n_tests++;
    if (gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL midop_accept: got gnt=%b required 01", gnt);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    seen   = 2'b00;
    rst_hi = 1'b1;
    repeat (2) begin
      @(negedge clk);
      seen   = seen | bus.resp_valid;
      rst_hi = rst_hi & bus.mul_reset;
    end
    reset = 1'b1;
    stall = 1'b0;
    #1;
    rst_hi = rst_hi & bus.mul_reset;
    @(negedge clk);
    n_tests++;
    if ({rst_hi, bus.mul_reset} !== 2'b10) begin
      n_fail++;
      $display("FAIL midop_mul_reset: got held=%b after_edge=%b required held=1 after_edge=0", rst_hi, bus.mul_reset);
    end
    repeat (12) begin
      @(negedge clk);
      seen = seen | bus.resp_valid;
    end
    n_tests++;
    if (seen !== 2'b00) begin
      n_fail++;
      $display("FAIL midop_no_resp: got resp_valid=%b required 00", seen);
    end
    exp_ptr = 0;
    exp_parked = 1'b0;
    run_job(2'b01, 16'h0003, 16'h0003, 1'b0, gnt, gos, opa, opb, rv, pdt, err, mrst, lat, to, rdyb);
    n_tests++;
    if ({to, gnt, 4'(gos), rv, pdt, err} !== {1'b0, 2'b01, 4'd1, 2'b01, 16'h0009, 1'b0}) begin
      n_fail++;
      $display("FAIL midop_next_job: got to=%b gnt=%b go=%0d rv=%b pdt=%h err=%b required gnt=01 go=1 rv=01 pdt=0009 err=0",
               to, gnt, gos, rv, pdt, err);
    end
    exp_ptr = 1;
    exp_parked = 1'b1;
  endtask

`ifdef BOOTH_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [1:0] gnt, rv, rdyb, egnt; logic [7:0] opa, opb; logic [15:0] pdt, epdt; logic err, mrst;
    int gos, lat, elat, g; bit to;
    stall = 1'b1;
    g     = pick(2'b11, exp_ptr);
    egnt  = 2'(1 << g);
    elat  = exp_parked ? 10 : 9;
    run_job(2'b11, 16'h3344, 16'h5566, 1'b0, gnt, gos, opa, opb, rv, pdt, err, mrst, lat, to, rdyb);
    stall = 1'b0;
    n_tests++;
    if ({to, gnt, rv, pdt, err, mrst} !== {1'b0, egnt, egnt, 16'h0000, 1'b1, 1'b1} || lat != elat) begin
      n_fail++;
      $display("FAIL timeout_abort: got to=%b gnt=%b rv=%b pdt=%h err=%b mul_reset=%b lat=%0d required gnt=%b rv=%b pdt=0000 err=1 mul_reset=1 lat=%0d",
               to, gnt, rv, pdt, err, mrst, lat, egnt, egnt, elat);
    end
    exp_ptr = (g + 1) % NREQ;
    exp_parked = 1'b0;
    g    = pick(2'b11, exp_ptr);
    egnt = 2'(1 << g);
    epdt = prod(16'h0B06, 16'hF907, g);
    run_job(2'b11, 16'h0B06, 16'hF907, 1'b0, gnt, gos, opa, opb, rv, pdt, err, mrst, lat, to, rdyb);
    n_tests++;
    if ({to, gnt, 4'(gos), rv, pdt, err} !== {1'b0, egnt, 4'd1, egnt, epdt, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_recover: got to=%b gnt=%b go=%0d rv=%b pdt=%h err=%b required gnt=%b go=1 rv=%b pdt=%h err=0",
               to, gnt, gos, rv, pdt, err, egnt, egnt, epdt);
    end
    exp_ptr = (g + 1) % NREQ;
    exp_parked = 1'b1;
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "bench time limit expired");
  end

  initial begin
    clk            = 1'b0;
    reset          = 1'b0;
    stall          = 1'b0;
    mul_lat        = 3;
    n_tests        = 0;
    n_fail         = 0;
    exp_ptr        = 0;
    exp_parked     = 1'b0;
    bus.req_valid  = 2'b00;
    bus.req_mplier = 16'h0000;
    bus.req_mpcand = 16'h0000;
    test_reset();
    test_basic();
    test_parked();
    test_back_to_back();
    test_random();
    test_reset_midop();
`ifdef BOOTH_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
